aes_cipher_core: RTL and testbench

- Iterative AES block-encryption core (FIPS-197) with one round per clock.
- Takes one 128-bit plaintext and a pre-expanded key schedule, and produces the 128-bit ciphertext after NR+1 clock cycles.
- Sits downstream of an external key-expansion unit; no key expansion inside.
- Includes the S-box (SubBytes), ShiftRows, MixColumns and AddRoundKey datapath.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_round_comb.sv | 52 +++++
 rtl/aes_cipher_core.sv | 75 +++++++
 tb/tb_aes_cipher_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) doubling, FSM states and block width.
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {INIT, ROUNDS, FINAL, DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte 0 is the most significant byte of the 128-bit word.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               is_final,
    output logic [BLOCK_W-1:0] next_state
);

    logic [7:0] sub_b   [16];
    logic [7:0] shift_b [16];
    logic [7:0] mix_b   [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sub_b[k] = sbox(state[BLOCK_W-1-8*k -: 8]);
        end
    end

    // Row r of column c takes the byte from column c+r (row r rotated left by r).
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_b[4*c+r] = sub_b[4*((c+r)%4)+r];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix_b[4*c+0] = xtime(shift_b[4*c+0]) ^ xtime(shift_b[4*c+1]) ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+1] = shift_b[4*c+0] ^ xtime(shift_b[4*c+1]) ^ xtime(shift_b[4*c+2])
                         ^ shift_b[4*c+2] ^ shift_b[4*c+3];
            mix_b[4*c+2] = shift_b[4*c+0] ^ shift_b[4*c+1] ^ xtime(shift_b[4*c+2])
                         ^ xtime(shift_b[4*c+3]) ^ shift_b[4*c+3];
            mix_b[4*c+3] = xtime(shift_b[4*c+0]) ^ shift_b[4*c+0] ^ shift_b[4*c+1]
                         ^ shift_b[4*c+2] ^ xtime(shift_b[4*c+3]);
        end
    end

    always_comb begin
        next_state = '0;
        for (int k = 0; k < 16; k++) begin
            next_state[BLOCK_W-1-8*k -: 8] = (is_final ? shift_b[k] : mix_b[k])
                                            ^ round_key[BLOCK_W-1-8*k -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES encryption, one round per clock, fed by an externally expanded key schedule.
// Round key 0 sits in the most significant 128 bits of keys.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic                       clks,
    input  logic                       reset,
    input  logic [BLOCK_W-1:0]         plainText,
    input  logic [BLOCK_W*(NR+1)-1:0]  keys,
    output logic [BLOCK_W-1:0]         encryptedText,
    output logic                       done
);

    localparam int KEYS_W = BLOCK_W * (NR + 1);

    state_t             state, state_next;
    logic [3:0]         round, round_next;
    logic [BLOCK_W-1:0] round_key, round_out, text_next;
    logic               done_next;

    assign round_key = keys[KEYS_W-1-BLOCK_W*int'(round) -: BLOCK_W];

    aes_round_comb u_round (
        .state      (encryptedText),
        .round_key  (round_key),
        .is_final   (state == FINAL),
        .next_state (round_out)
    );

    always_ff @(posedge clks) begin
        if (reset) begin
            state         <= INIT;
            round         <= 4'd0;
            encryptedText <= '0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            round         <= round_next;
            encryptedText <= text_next;
            done          <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        round_next = round;
        text_next  = encryptedText;
        done_next  = done;
        case (state)
            INIT: begin
                text_next  = plainText ^ round_key;
                round_next = 4'd1;
                state_next = ROUNDS;
            end
            ROUNDS: begin
                text_next  = round_out;
                round_next = round + 4'd1;
                if (round == 4'(NR - 1)) state_next = FINAL;
            end
            FINAL: begin
                text_next  = round_out;
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                // Result is frozen until the next reset pulse.
            end
            default: state_next = INIT;
        endcase
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: known FIPS-197 vectors plus random blocks against a byte-level AES model.
module tb_aes_cipher_core;

    logic           clks = 1'b0;
    logic           rst4, rst8;
    logic [127:0]   pt4, pt8, ct4, ct8;
    logic [1407:0]  keys4;
    logic [1919:0]  keys8;
    logic           done4, done8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sbx [256];
    logic [31:0] ws  [60];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs [8];

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_cipher_core #(.NK(4)) dut4 (
        .clks(clks), .reset(rst4), .plainText(pt4), .keys(keys4),
        .encryptedText(ct4), .done(done4)
    );

    aes_cipher_core #(.NK(8)) dut8 (
        .clks(clks), .reset(rst8), .plainText(pt8), .keys(keys8),
        .encryptedText(ct8), .done(done8)
    );

    always #5 clks = ~clks;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box derived from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbx[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) ws[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = ws[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            ws[i] = ws[i-nk] ^ t;
        end
    endtask

    task automatic load_keys4(input logic [127:0] key);
        expand({key, 128'h0}, 4);
        for (int i = 0; i < 44; i++) keys4[1407-32*i -: 32] = ws[i];
    endtask

    task automatic load_keys8(input logic [255:0] key);
        expand(key, 8);
        for (int i = 0; i < 60; i++) keys8[1919-32*i -: 32] = ws[i];
    endtask

    // Encrypts with the schedule currently held in ws, on a 4x4 row/column byte matrix.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   st  [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   m   [4];
        logic [127:0] res;
        m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ ws[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r][c] = sbx[st[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < nr) begin
                        st[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++) st[r][c] = st[r][c] ^ gmul(m[(j-r+4)%4], tmp[j][c]);
                    end else begin
                        st[r][c] = tmp[r][c];
                    end
                end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ ws[4*rnd+c][31-8*r -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = st[r][c];
        return res;
    endfunction

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run4(input logic [127:0] pt, input logic [127:0] key);
        rst4 = 1'b1;
        pt4  = pt;
        load_keys4(key);
        repeat (2) tick();
        rst4 = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_ct, rpt;
        logic [255:0] rkey;

        rst4 = 1'b1; rst8 = 1'b1;
        pt4 = '0; pt8 = '0; keys4 = '0; keys8 = '0;
        build_sbox();

        // Reset state of both instances.
        repeat (2) tick();
        check("reset_ct4", ct4, '0);
        check("reset_done4", {127'b0, done4}, '0);
        check("reset_ct8", ct8, '0);
        check("reset_done8", {127'b0, done8}, '0);

        // Reference model sanity against the published answers.
        expand({C1_KEY, 128'h0}, 4);
        check("model_c1", model_encrypt(C1_PT, 10), C1_CT);

        // FIPS-197 C.1 with intermediate states, latency and DONE hold.
        run4(C1_PT, C1_KEY);
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 1) check("c1_edge1", ct4, 128'h00102030405060708090a0b0c0d0e0f0);
            if (e == 2) check("c1_edge2", ct4, 128'h89d810e8855ace682d1843d8cb128fe4);
            if (e <= 10) check($sformatf("c1_done_low_e%0d", e), {127'b0, done4}, '0);
        end
        check("c1_ct", ct4, C1_CT);
        check("c1_done", {127'b0, done4}, 128'd1);
        repeat (3) tick();
        check("c1_hold_ct", ct4, C1_CT);
        pt4 = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
        repeat (2) tick();
        check("done_hold_pt_change_ct", ct4, C1_CT);
        check("done_hold_pt_change_done", {127'b0, done4}, 128'd1);

        // Table of NK=4 vectors: two known answers plus random blocks scored by the model.
        vecs[0] = '{C1_PT, C1_KEY, C1_CT};
        vecs[1] = '{128'h0, 128'h0, Z_CT};
        for (int i = 2; i < 8; i++) begin
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            expand({vecs[i].key, 128'h0}, 4);
            vecs[i].ct  = model_encrypt(vecs[i].pt, 10);
        end
        for (int i = 0; i < 8; i++) begin
            run4(vecs[i].pt, vecs[i].key);
            repeat (10) tick();
            check($sformatf("vec%0d_done_early", i), {127'b0, done4}, '0);
            tick();
            check($sformatf("vec%0d_ct", i), ct4, vecs[i].ct);
            check($sformatf("vec%0d_done", i), {127'b0, done4}, 128'd1);
        end

        // Reset after edge 5 of a C.1 run, restart on the all-zero vector.
        run4(C1_PT, C1_KEY);
        repeat (5) tick();
        rst4 = 1'b1;
        pt4  = '0;
        load_keys4('0);
        tick();
        check("midreset_ct", ct4, '0);
        check("midreset_done", {127'b0, done4}, '0);
        rst4 = 1'b0;
        repeat (10) tick();
        check("midreset_done_early", {127'b0, done4}, '0);
        tick();
        check("midreset_ct_final", ct4, Z_CT);
        check("midreset_done_final", {127'b0, done4}, 128'd1);

        // NK=8: FIPS-197 C.3 vector then random blocks.
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                rpt    = C1_PT;
                rkey   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
                exp_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
            end else begin
                rpt  = {$urandom, $urandom, $urandom, $urandom};
                rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                expand(rkey, 8);
                exp_ct = model_encrypt(rpt, 14);
            end
            rst8 = 1'b1;
            pt8  = rpt;
            load_keys8(rkey);
            repeat (2) tick();
            rst8 = 1'b0;
            repeat (14) tick();
            check($sformatf("nk8_%0d_done_early", i), {127'b0, done8}, '0);
            tick();
            check($sformatf("nk8_%0d_ct", i), ct8, exp_ct);
            check($sformatf("nk8_%0d_done", i), {127'b0, done8}, 128'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
